// File: rtl/cpu_cu.sv
// rtl/cpu_cu.sv - multicycle fetch/decode/execute control unit for the 16-bit CPU
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   IR[15:0]          instruction register contents from the execution unit
//   N, Z, C           ALU flags from the execution unit (used by branches)
//   we, W_Adr         register-file write enable and write address
//   R_Adr, S_Adr      register-file read addresses
//   s_sel             1 selects D_in as the S operand
//   ALU_OP[3:0]       ALU operation (ALU_PASS_S when idle)
//   ad_sel            memory address source: 1 = Reg_out, 0 = PC
//   PC_sel            PC load source: 1 = D_out, 0 = PC + sext(IR[7:0])
//   PC_ld, PC_inc     PC load / increment strobes
//   IR_ld             IR load from D_in
//   mw_en, mr_en      memory write / read strobes
//   halt              high while halted
//   state[2:0]        current FSM state for debug
module cpu_cu #(
  parameter logic [3:0] ALU_PASS_S = 4'h8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] IR,
  input  logic        N,
  input  logic        Z,
  input  logic        C,
  output logic        we,
  output logic [2:0]  W_Adr,
  output logic [2:0]  R_Adr,
  output logic [2:0]  S_Adr,
  output logic        s_sel,
  output logic [3:0]  ALU_OP,
  output logic        ad_sel,
  output logic        PC_sel,
  output logic        PC_ld,
  output logic        PC_inc,
  output logic        IR_ld,
  output logic        mw_en,
  output logic        mr_en,
  output logic        halt,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_ST   = 4'h9;
  localparam logic [3:0] OP_BRZ  = 4'hA;
  localparam logic [3:0] OP_BRN  = 4'hB;
  localparam logic [3:0] OP_BRC  = 4'hC;
  localparam logic [3:0] OP_JMP  = 4'hD;
  localparam logic [3:0] OP_NOP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Instruction fields
  logic [3:0] op;
  logic [2:0] fld_w;
  logic [2:0] fld_r;
  logic [2:0] fld_s;
  logic       unused_ir;

  assign op        = IR[15:12];
  assign fld_w     = IR[11:9];
  assign fld_r     = IR[8:6];
  assign fld_s     = IR[5:3];
  // The branch offset is consumed by the execution unit, not here.
  assign unused_ir = ^IR[2:0];

  state_t     state_q, state_d;
  logic       we_q, we_d;
  logic [2:0] w_adr_q, w_adr_d;
  logic [2:0] r_adr_q, r_adr_d;
  logic [2:0] s_adr_q, s_adr_d;
  logic       s_sel_q, s_sel_d;
  logic [3:0] alu_op_q, alu_op_d;
  logic       ad_sel_q, ad_sel_d;
  logic       pc_sel_q, pc_sel_d;
  logic       pc_ld_q, pc_ld_d;
  logic       pc_inc_q, pc_inc_d;
  logic       ir_ld_q, ir_ld_d;
  logic       mw_en_q, mw_en_d;
  logic       mr_en_q, mr_en_d;
  logic       halt_q, halt_d;
  // Conditional-branch enables {C, N, Z}; the flag itself is sampled live in EXEC.
  logic [2:0] br_q, br_d;

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RST:    state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        if (op == OP_HALT)     state_d = ST_HALT;
        else if (op == OP_NOP) state_d = ST_FETCH;
        else                   state_d = ST_EXEC;
      end
      ST_EXEC:   state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_RST;
    endcase
  end

  // Output image for the state being entered. IR is already stable when
  // entering EXEC (it was loaded at the end of FETCH), so registering the
  // decode here gives the same values as decoding from the state register.
  always_comb begin
    we_d     = 1'b0;
    w_adr_d  = 3'd0;
    r_adr_d  = 3'd0;
    s_adr_d  = 3'd0;
    s_sel_d  = 1'b0;
    alu_op_d = ALU_PASS_S;
    ad_sel_d = 1'b0;
    pc_sel_d = 1'b0;
    pc_ld_d  = 1'b0;
    pc_inc_d = 1'b0;
    ir_ld_d  = 1'b0;
    mw_en_d  = 1'b0;
    mr_en_d  = 1'b0;
    halt_d   = 1'b0;
    br_d     = 3'b000;
    case (state_d)
      ST_FETCH: begin
        mr_en_d  = 1'b1;
        ir_ld_d  = 1'b1;
        pc_inc_d = 1'b1;
      end
      ST_EXEC: begin
        if (op[3] == 1'b0) begin
          w_adr_d  = fld_w;
          r_adr_d  = fld_r;
          s_adr_d  = fld_s;
          alu_op_d = {1'b0, op[2:0]};
          we_d     = 1'b1;
        end else begin
          case (op)
            OP_LD: begin
              r_adr_d  = fld_r;
              ad_sel_d = 1'b1;
              mr_en_d  = 1'b1;
              s_sel_d  = 1'b1;
              w_adr_d  = fld_w;
              we_d     = 1'b1;
            end
            OP_ST: begin
              r_adr_d  = fld_r;
              ad_sel_d = 1'b1;
              s_adr_d  = fld_s;
              mw_en_d  = 1'b1;
            end
            OP_BRZ: br_d = 3'b001;
            OP_BRN: br_d = 3'b010;
            OP_BRC: br_d = 3'b100;
            OP_JMP: begin
              // Target register goes through the S port and ALU pass-through.
              s_adr_d  = fld_r;
              pc_sel_d = 1'b1;
              pc_ld_d  = 1'b1;
            end
            default: ;
          endcase
        end
      end
      ST_HALT: halt_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_RST;
      we_q     <= 1'b0;
      w_adr_q  <= 3'd0;
      r_adr_q  <= 3'd0;
      s_adr_q  <= 3'd0;
      s_sel_q  <= 1'b0;
      alu_op_q <= ALU_PASS_S;
      ad_sel_q <= 1'b0;
      pc_sel_q <= 1'b0;
      pc_ld_q  <= 1'b0;
      pc_inc_q <= 1'b0;
      ir_ld_q  <= 1'b0;
      mw_en_q  <= 1'b0;
      mr_en_q  <= 1'b0;
      halt_q   <= 1'b0;
      br_q     <= 3'b000;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      w_adr_q  <= w_adr_d;
      r_adr_q  <= r_adr_d;
      s_adr_q  <= s_adr_d;
      s_sel_q  <= s_sel_d;
      alu_op_q <= alu_op_d;
      ad_sel_q <= ad_sel_d;
      pc_sel_q <= pc_sel_d;
      pc_ld_q  <= pc_ld_d;
      pc_inc_q <= pc_inc_d;
      ir_ld_q  <= ir_ld_d;
      mw_en_q  <= mw_en_d;
      mr_en_q  <= mr_en_d;
      halt_q   <= halt_d;
      br_q     <= br_d;
    end
  end

  // State-changing strobes are gated by reset in the same cycle so an
  // interrupted instruction commits nothing on the edge that enters RST.
  assign we     = we_q & ~reset;
  assign mw_en  = mw_en_q & ~reset;
  assign PC_inc = pc_inc_q & ~reset;
  assign IR_ld  = ir_ld_q & ~reset;
  assign PC_ld  = (pc_ld_q | (br_q[0] & Z) | (br_q[1] & N) | (br_q[2] & C)) & ~reset;

  assign W_Adr  = w_adr_q;
  assign R_Adr  = r_adr_q;
  assign S_Adr  = s_adr_q;
  assign s_sel  = s_sel_q;
  assign ALU_OP = alu_op_q;
  assign ad_sel = ad_sel_q;
  assign PC_sel = pc_sel_q;
  assign mr_en  = mr_en_q;
  assign halt   = halt_q;
  assign state  = state_q;

endmodule

// File: tb/tb_cpu_cu.sv
// tb/tb_cpu_cu.sv - randomized self-checking bench for cpu_cu against an instruction-level model
module tb_cpu_cu;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] IR;
  logic        N, Z, C;
  logic        we, s_sel, ad_sel, PC_sel, PC_ld, PC_inc, IR_ld, mw_en, mr_en, halt;
  logic [2:0]  W_Adr, R_Adr, S_Adr, state;
  logic [3:0]  ALU_OP;

  int checks = 0;
  int errors = 0;

  typedef logic [25:0] ovec_t;
  ovec_t obs;

  always #5 clk = ~clk;

  cpu_cu dut (
    .clk(clk), .reset(reset), .IR(IR), .N(N), .Z(Z), .C(C),
    .we(we), .W_Adr(W_Adr), .R_Adr(R_Adr), .S_Adr(S_Adr), .s_sel(s_sel),
    .ALU_OP(ALU_OP), .ad_sel(ad_sel), .PC_sel(PC_sel), .PC_ld(PC_ld),
    .PC_inc(PC_inc), .IR_ld(IR_ld), .mw_en(mw_en), .mr_en(mr_en),
    .halt(halt), .state(state)
  );

  assign obs = {we, W_Adr, R_Adr, S_Adr, s_sel, ALU_OP, ad_sel, PC_sel,
                PC_ld, PC_inc, IR_ld, mw_en, mr_en, halt, state};

  // Expected control word for a phase of an instruction.
  // ph: 0 reset/idle, 1 fetch, 2 decode, 3 execute, 4 halted.
  function automatic ovec_t model(input int ph, input logic [15:0] ir,
                                  input logic n, input logic z, input logic c,
                                  input logic rst);
    logic       e_we, e_ssel, e_ad, e_pcs, e_pcl, e_pci, e_irl, e_mw, e_mr, e_h;
    logic [2:0] e_w, e_r, e_s;
    logic [3:0] e_alu;
    int         opc;
    opc = int'(ir[15:12]);
    {e_we, e_ssel, e_ad, e_pcs, e_pcl, e_pci, e_irl, e_mw, e_mr, e_h} = 10'b0;
    e_w = 3'd0; e_r = 3'd0; e_s = 3'd0; e_alu = 4'h8;
    if (ph == 1) begin
      e_mr = 1'b1; e_irl = 1'b1; e_pci = 1'b1;
    end else if (ph == 4) begin
      e_h = 1'b1;
    end else if (ph == 3) begin
      if (opc < 8) begin
        e_w = ir[11:9]; e_r = ir[8:6]; e_s = ir[5:3]; e_alu = 4'(opc); e_we = 1'b1;
      end else if (opc == 8) begin
        e_r = ir[8:6]; e_ad = 1'b1; e_mr = 1'b1; e_ssel = 1'b1; e_w = ir[11:9]; e_we = 1'b1;
      end else if (opc == 9) begin
        e_r = ir[8:6]; e_ad = 1'b1; e_s = ir[5:3]; e_mw = 1'b1;
      end else if (opc == 10) e_pcl = z;
      else if (opc == 11) e_pcl = n;
      else if (opc == 12) e_pcl = c;
      else if (opc == 13) begin
        e_s = ir[8:6]; e_pcs = 1'b1; e_pcl = 1'b1;
      end
    end
    if (rst) begin
      e_we = 1'b0; e_mw = 1'b0; e_pcl = 1'b0; e_pci = 1'b0; e_irl = 1'b0;
    end
    return {e_we, e_w, e_r, e_s, e_ssel, e_alu, e_ad, e_pcs, e_pcl, e_pci,
            e_irl, e_mw, e_mr, e_h, 3'(ph)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from FETCH; flags < 0 means random flags in EXEC.
  task automatic run_seq(input logic [15:0] ir, input int flags, input string tag);
    ovec_t exp;
    logic [3:0] opc;
    opc = ir[15:12];
    {N, Z, C} = 3'($urandom);
    @(negedge clk);
    exp = model(1, IR, N, Z, C, reset);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s fetch: got %h expected %h", tag, obs, exp);
    end
    tick();
    IR = ir;
    {N, Z, C} = 3'($urandom);
    @(negedge clk);
    exp = model(2, IR, N, Z, C, reset);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s decode: got %h expected %h", tag, obs, exp);
    end
    tick();
    if (opc == 4'hF || opc == 4'hE) return;
    if (flags < 0) {N, Z, C} = 3'($urandom);
    else           {N, Z, C} = 3'(flags);
    @(negedge clk);
    exp = model(3, IR, N, Z, C, reset);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s exec ir=%h: got %h expected %h", tag, ir, obs, exp);
    end
    tick();
  endtask

  task automatic test_reset();
    ovec_t exp;
    tick();
    @(negedge clk);
    exp = model(0, IR, N, Z, C, 1'b1);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset_held: got %h expected %h", obs, exp); end
    tick();
    reset = 1'b0;
    @(negedge clk);
    exp = model(0, IR, N, Z, C, 1'b0);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset_release: got %h expected %h", obs, exp); end
    tick();
    @(negedge clk);
    exp = model(1, IR, N, Z, C, 1'b0);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL first_fetch: got %h expected %h", obs, exp); end
    #1 reset = 1'b1;
    #1;
    exp = model(1, IR, N, Z, C, 1'b1);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL fetch_under_reset: got %h expected %h", obs, exp); end
    tick();
    reset = 1'b0;
    @(negedge clk);
    exp = model(0, IR, N, Z, C, 1'b0);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL fetch_reset_state: got %h expected %h", obs, exp); end
    tick();
  endtask

  task automatic test_alu();
    logic [15:0] ir;
    run_seq(16'h0298, -1, "add_fixed");
    for (int i = 0; i < 16; i++) begin
      ir = 16'($urandom);
      ir[15] = 1'b0;
      run_seq(ir, -1, "alu_rand");
    end
  endtask

  task automatic test_ld_st();
    run_seq(16'h8A80, -1, "ld_fixed");
    run_seq(16'h9298, -1, "st_fixed");
    for (int i = 0; i < 8; i++) run_seq({4'h8 + 4'($urandom_range(0, 1)), 12'($urandom)}, -1, "ldst_rand");
  endtask

  task automatic test_branch();
    run_seq(16'hA0FE, 3'b010, "brz_taken");
    run_seq(16'hA0FE, 3'b101, "brz_not_taken");
    run_seq(16'hB012, 3'b100, "brn_taken");
    run_seq(16'hB012, 3'b011, "brn_not_taken");
    run_seq(16'hC080, 3'b001, "brc_taken");
    run_seq(16'hC080, 3'b110, "brc_not_taken");
    run_seq(16'hE000, -1, "nop");
    run_seq(16'hD180, -1, "jmp_fixed");
  endtask

  task automatic test_halt();
    ovec_t exp;
    run_seq(16'hF000, -1, "halt_entry");
    for (int i = 0; i < 10; i++) begin
      {N, Z, C} = 3'($urandom);
      @(negedge clk);
      exp = model(4, IR, N, Z, C, 1'b0);
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL halt_hold cycle %0d: got %h expected %h", i, obs, exp); end
      tick();
    end
    reset = 1'b1;
    @(negedge clk);
    exp = model(4, IR, N, Z, C, 1'b1);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL halt_reset_asserted: got %h expected %h", obs, exp); end
    tick();
    @(negedge clk);
    exp = model(0, IR, N, Z, C, 1'b1);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL halt_exit: got %h expected %h", obs, exp); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    ovec_t exp;
    @(negedge clk);
    exp = model(1, IR, N, Z, C, 1'b0);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL mid_fetch: got %h expected %h", obs, exp); end
    tick();
    IR = 16'h9298;
    tick();
    reset = 1'b1;
    @(negedge clk);
    exp = model(3, IR, N, Z, C, 1'b1);
    checks++;
    if (mw_en !== 1'b0) begin errors++; $display("FAIL mid_st_mw_en: got %b expected 0", mw_en); end
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL mid_st_exec: got %h expected %h", obs, exp); end
    tick();
    reset = 1'b0;
    @(negedge clk);
    exp = model(0, IR, N, Z, C, 1'b0);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL mid_st_after: got %h expected %h", obs, exp); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [15:0] ir;
    for (int i = 0; i < 40; i++) begin
      ir = 16'($urandom);
      ir[15:12] = 4'($urandom_range(0, 14));
      run_seq(ir, -1, "b2b_rand");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    IR    = 16'h0000;
    {N, Z, C} = 3'b000;
    test_reset();
    test_alu();
    test_ld_st();
    test_branch();
    test_reset_mid();
    test_back_to_back();
    test_halt();
    run_seq(16'h0298, -1, "post_halt");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_cu.md
Name: cpu_cu

Overview:
Multicycle control unit for the 16-bit CPU. Sequences fetch, decode and execute by driving every control input of cpu_eu. Consumes the execution unit's IR_out and N/Z/C flags. Also drives the memory read/write strobes. Executes one instruction every 3 cycles; a taken branch or jump costs the same.

Parameters:
ALU_PASS_S, 4'h8, ALU_OP code that passes the S operand to D_out unchanged.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
IR  input  16  instruction register contents (from cpu_eu IR_out)
N  input  1  negative flag from cpu_eu
Z  input  1  zero flag from cpu_eu
C  input  1  carry flag from cpu_eu
we  output  1  register-file write enable
W_Adr  output  3  register write address
R_Adr  output  3  register R read address
S_Adr  output  3  register S read address
s_sel  output  1  1 selects D_in as the S operand
ALU_OP  output  4  ALU operation
ad_sel  output  1  Addr source: 1 = Reg_out, 0 = PC
PC_sel  output  1  PC load source: 1 = D_out, 0 = PC + sext(IR[7:0])
PC_ld  output  1  PC load
PC_inc  output  1  PC increment
IR_ld  output  1  IR load from D_in
mw_en  output  1  memory write strobe
mr_en  output  1  memory read strobe
halt  output  1  high while in HALT
state  output  3  current state, for debug

Behaviour:
- Memory read is combinational: D_in is valid in the same cycle as Addr/mr_en. A write commits on the clk edge ending a cycle with mw_en=1.
- Instruction format: op = IR[15:12], w = IR[11:9], r = IR[8:6], s = IR[5:3], off = IR[7:0].
- Outputs are Moore-style: decoded from the state register and IR only. The sole exception is PC_ld in BRANCH, which also depends on N/Z/C.
- Defaults in every state: all 1-bit outputs = 0, addresses = 0, ALU_OP = ALU_PASS_S.
- States and encodings: RST 3'd0, FETCH 3'd1, DECODE 3'd2, EXEC 3'd3, HALT 3'd4.
- RST: no outputs asserted. Next state is FETCH.
- FETCH: ad_sel=0, mr_en=1, IR_ld=1, PC_inc=1. IR <= M[PC] and PC <= PC+1 on the same edge. Next state is DECODE.
- DECODE: no outputs asserted. Next state:
  - HALT if op = 4'hF.
  - FETCH if op = 4'hE (NOP, also covers any undefined op).
  - EXEC otherwise.
- EXEC, by opcode:
  - op 0x0-0x7 (ALU): W_Adr=w, R_Adr=r, S_Adr=s, ALU_OP={1'b0,IR[14:12]}, we=1.
  - op 0x8 (LD): R_Adr=r, ad_sel=1, mr_en=1, s_sel=1, ALU_OP=ALU_PASS_S, W_Adr=w, we=1. Result: R[w] <= M[R[r]].
  - op 0x9 (ST): R_Adr=r, ad_sel=1, S_Adr=s, ALU_OP=ALU_PASS_S, mw_en=1. Result: M[R[r]] <= R[s].
  - op 0xA/0xB/0xC (BRZ/BRN/BRC): PC_sel=0, PC_ld = Z/N/C respectively. When taken, PC <= PC+1+sext(off), i.e. relative to the already-incremented PC. Flags are sampled in the EXEC cycle.
  - op 0xD (JMP): S_Adr=r, s_sel=0, ALU_OP=ALU_PASS_S, PC_sel=1, PC_ld=1. Result: PC <= R[r].
  - In all cases the next state is FETCH.
- HALT: halt=1, no other outputs asserted. Only reset exits this state.
- Reset handling:
  - reset=1 forces we, mw_en, PC_ld, PC_inc and IR_ld to 0 combinationally in that cycle, so an instruction interrupted mid-sequence commits nothing.
  - On the following edge, state <= RST.
  - reset overrides every other transition, including HALT.
- Reset values (state RST): state=3'd0, halt=0, all strobes 0, ALU_OP=ALU_PASS_S, addresses 0.
- PC_inc and PC_ld are never both 1. IR_ld is asserted only in FETCH. we and mw_en are never both 1.
- Latency: 3 cycles per instruction; NOP takes 2 cycles (FETCH, DECODE). The first FETCH occurs 1 cycle after reset deasserts.

Test Plan:
- Reset held 2 cycles, then released: state 0 -> 1 -> 2. In FETCH: mr_en=1, IR_ld=1, PC_inc=1, and all enables are 0 while reset is high.
- ADD with IR=16'h0298 (op0, w=1, r=2, s=3): in EXEC, we=1, W_Adr=1, R_Adr=2, S_Adr=3, ALU_OP=4'h0; the next cycle is FETCH.
- LD with IR=16'h8A80 (w=5, r=2): EXEC gives ad_sel=1, mr_en=1, s_sel=1, we=1, W_Adr=5, ALU_OP=4'h8. ST with IR=16'h9298: mw_en=1, we=0, S_Adr=3.
- BRZ with IR=16'hA0FE (off=-2): Z=1 gives PC_ld=1, PC_sel=0, PC_inc=0. Repeating with Z=0 gives PC_ld=0; the next state is FETCH in both cases.
- JMP with IR=16'hD180 (r=6): S_Adr=6, PC_sel=1, PC_ld=1. HALT with IR=16'hF000: halt=1 stays latched for 10 cycles; asserting reset returns state to 0.
- Reset asserted during EXEC of a ST: mw_en=0 in that cycle, no memory write occurs, and state=0 on the next edge.
